// File: rtl/cpu_pkg.sv
// cpu_pkg: shared types and defaults for the RAM arbiter between cpu, loader and ram
package cpu_pkg;
  typedef enum logic [1:0] {IDLE, OWN0, OWN1} arb_state_t;
  localparam int DEF_ADDR_W = 8;
  localparam int DEF_DATA_W = 32;
  localparam int PORT_CPU = 0;
  localparam int PORT_LDR = 1;
endpackage

// File: rtl/ram_arbiter.sv
// ram_arbiter: round-robin sharing of the single-port RAM between CPU (port 0) and loader (port 1),
// with per-port lock for bursts bounded by a fairness hold limit.
module ram_arbiter
  import cpu_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int MAX_HOLD = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        req,
  input  logic [1:0]        lock,
  input  logic [1:0]        we,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic [1:0]        gnt,
  output logic [1:0]        rvalid,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_data,
  output logic              ram_load,
  output logic              ram_save,
  input  logic [DATA_W-1:0] ram_value
);
  localparam int HW = $clog2(MAX_HOLD + 1);
  localparam logic [HW-1:0] HMAX = HW'(MAX_HOLD);
  arb_state_t state_q, state_d;
  logic [HW-1:0] hold_q, hold_d;
  logic last_q;
  logic [1:0] rvalid_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  logic own, g, any;
  always_comb begin
    state_d = state_q;
    hold_d = hold_q;
    own = state_q == OWN1;
    g = 1'b0;
    any = 1'b0;
    if (state_q == IDLE) begin
      any = |req;
      g = &req ? ~last_q : req[PORT_LDR];
      state_d = (any && lock[g]) ? (g ? OWN1 : OWN0) : IDLE;
      hold_d = (any && lock[g]) ? HW'(1) : '0;
    end else if ((req[~own] && hold_q == HMAX) || !req[own]) begin
      // owner gave up or exhausted its hold: the waiting port gets this very cycle
      any = req[~own];
      g = ~own;
      state_d = IDLE;
      hold_d = '0;
    end else begin
      any = 1'b1;
      g = own;
      state_d = lock[own] ? state_q : IDLE;
      hold_d = !lock[own] ? '0 : (req[~own] && hold_q != HMAX) ? hold_q + 1'b1 : hold_q;
    end
    any = any & ~reset;
  end
  assign gnt = {any & g, any & ~g};
  assign ram_load = any & ~we[g];
  assign ram_save = any & we[g];
  assign ram_addr = any ? (g ? addr1 : addr0) : addr_q;
  assign ram_data = any ? (g ? wdata1 : wdata0) : data_q;
  assign rvalid = reset ? 2'b00 : rvalid_q;
  assign rdata = ram_value;
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      hold_q <= '0;
      last_q <= 1'b1;
      rvalid_q <= '0;
      addr_q <= '0;
      data_q <= '0;
    end else begin
      state_q <= state_d;
      hold_q <= hold_d;
      last_q <= any ? g : last_q;
      rvalid_q <= gnt & ~we;
      addr_q <= ram_addr;
      data_q <= ram_data;
    end
  end
endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: directed and random checks of ram_arbiter against a behavioural arbitration model
module tb_ram_arbiter;
  import cpu_pkg::*;
  localparam int AW = 8;
  localparam int DW = 32;
  localparam int MH = 4;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [1:0] req = '0, lock = '0, we = '0;
  logic [AW-1:0] addr0 = '0, addr1 = '0;
  logic [DW-1:0] wdata0 = '0, wdata1 = '0;
  logic [1:0] gnt, rvalid;
  logic [DW-1:0] rdata, ram_data, ram_value;
  logic [AW-1:0] ram_addr;
  logic ram_load, ram_save;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;

  ram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_HOLD(MH)) dut (
    .clk(clk), .reset(reset), .req(req), .lock(lock), .we(we),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt(gnt), .rvalid(rvalid), .rdata(rdata),
    .ram_addr(ram_addr), .ram_data(ram_data), .ram_load(ram_load), .ram_save(ram_save),
    .ram_value(ram_value)
  );

  function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
    return {a, ~a, 8'h5A, a};
  endfunction

  // RAM: registered read, one-cycle latency
  logic [DW-1:0] mem [256];
  bit [255:0] wr_ok;
  always @(posedge clk) begin
    if (ram_save) begin
      mem[ram_addr] <= ram_data;
      wr_ok[ram_addr] <= 1'b1;
    end
    if (ram_load) ram_value <= wr_ok[ram_addr] ? mem[ram_addr] : init_val(ram_addr);
  end

  int m_owner = -1, m_last = 1, m_run = 0, m_prev_rd = -1;
  logic [DW-1:0] m_prev_val = '0, m_data = '0;
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] ref_mem [int];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input bit d = 1'b0, input logic [1:0] w = 2'b00);
    int g, o, x;
    logic [1:0] eg, er;
    logic [AW-1:0] a;
    logic [DW-1:0] wd;
    #1;
    g = -1;
    if (!reset) begin
      if (m_owner < 0) begin
        if (req == 2'b11) g = 1 - m_last;
        else if (req[0]) g = 0;
        else if (req[1]) g = 1;
      end else begin
        o = m_owner;
        x = 1 - o;
        if (req[x] && m_run >= MH) g = x;
        else if (req[o]) g = o;
        else if (req[x]) g = x;
      end
    end
    eg = (g < 0) ? 2'b00 : 2'b01 << g;
    er = (reset || m_prev_rd < 0) ? 2'b00 : 2'b01 << m_prev_rd;
    a = (g == 1) ? addr1 : addr0;
    wd = (g == 1) ? wdata1 : wdata0;
    chk("gnt", gnt, eg);
    chk("ram_load", ram_load, g >= 0 && !we[g]);
    chk("ram_save", ram_save, g >= 0 && we[g]);
    chk("rvalid", rvalid, er);
    if (er != 2'b00) chk("rdata", rdata, m_prev_val);
    if (!reset) begin
      chk("ram_addr", ram_addr, g >= 0 ? a : m_addr);
      chk("ram_data", ram_data, g >= 0 ? wd : m_data);
    end
    if (d) chk("dir_gnt", gnt, w);
    @(posedge clk);
    if (reset) begin
      m_owner = -1; m_last = 1; m_run = 0; m_prev_rd = -1; m_addr = '0; m_data = '0;
    end else begin
      m_prev_rd = -1;
      if (g >= 0) begin
        m_last = g; m_addr = a; m_data = wd;
        if (we[g]) ref_mem[int'(a)] = wd;
        else begin
          m_prev_rd = g;
          m_prev_val = ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : init_val(a);
        end
      end
      if (m_owner >= 0 && g == m_owner && lock[g]) begin
        if (req[1-g] && m_run < MH) m_run++;
      end else if (m_owner < 0 && g >= 0 && lock[g]) begin
        m_owner = g; m_run = 1;
      end else begin
        m_owner = -1; m_run = 0;
      end
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1; req = 2'b00; lock = 2'b00;
    step();
    reset = 1'b0;
  endtask

  initial begin
    @(negedge clk);
    // reset overrides simultaneous requests
    reset = 1'b1; req = 2'b11; we = 2'b00;
    step(1'b1, 2'b00);
    step(1'b1, 2'b00);
    reset = 1'b0;
    // loader write then CPU read of the same word
    req = 2'b10; we = 2'b10; addr1 = 8'd3; wdata1 = 32'h8000_030F;
    step(1'b1, 2'b10);
    req = 2'b01; we = 2'b00; addr0 = 8'd3;
    step(1'b1, 2'b01);
    req = 2'b00;
    #1 chk("t2_rvalid", rvalid, 2'b01);
    chk("t2_rdata", rdata, 32'h8000_030F);
    step();
    // unlocked ties alternate, port 0 first
    do_reset();
    req = 2'b11; lock = 2'b00; we = 2'b00; addr0 = 8'd1; addr1 = 8'd2;
    for (int i = 0; i < 6; i++) step(1'b1, (i % 2) ? 2'b10 : 2'b01);
    // locked port 1 held for MAX_HOLD grants, then forced release
    req = 2'b01; lock = 2'b00;
    step(1'b1, 2'b01);
    req = 2'b11; lock = 2'b10;
    for (int i = 0; i < MH; i++) step(1'b1, 2'b10);
    step(1'b1, 2'b01);
    chk("t4_state", dut.state_q, IDLE);
    lock = 2'b00;
    step(1'b1, 2'b10);
    // owner drops request mid-burst: waiter granted the same cycle
    req = 2'b01; lock = 2'b01;
    step(1'b1, 2'b01);
    req = 2'b11;
    step(1'b1, 2'b01);
    req = 2'b10;
    step(1'b1, 2'b10);
    chk("t5_state", dut.state_q, IDLE);
    // reset in OWN1 right after a read grant drops the pending rvalid
    req = 2'b10; lock = 2'b10; we = 2'b00; addr1 = 8'd3;
    step(1'b1, 2'b10);
    chk("t6_own", dut.state_q, OWN1);
    reset = 1'b1;
    #1 chk("t6_rvalid", rvalid, 2'b00);
    step(1'b1, 2'b00);
    reset = 1'b0; req = 2'b00; lock = 2'b00;
    step(1'b1, 2'b00);
    chk("t6_state", dut.state_q, IDLE);
    req = 2'b11;
    step(1'b1, 2'b01);
    // random traffic
    for (int i = 0; i < 600; i++) begin
      reset = ($urandom_range(0, 63) == 0);
      req = 2'($urandom);
      lock = ($urandom_range(0, 2) == 0) ? 2'b00 : 2'($urandom);
      we = 2'($urandom);
      addr0 = AW'($urandom_range(0, 15));
      addr1 = AW'($urandom_range(0, 15));
      wdata0 = $urandom;
      wdata1 = $urandom;
      step();
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
